// File: rtl/sni_match_pkg.sv
// Shared types and constants for the bitap SNI matcher.
// Optional build feature: SNI_WILDCARD_EN (adds '*' wildcard positions).
package sni_match_pkg;

  localparam int unsigned PAT_LEN_DEF = 16;
  localparam logic [7:0]  DOT_BYTE    = 8'h2E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_REPORT
  } fsm_state_t;

  typedef logic [PAT_LEN_DEF-1:0] bitap_state_t;
  typedef logic [PAT_LEN_DEF-1:0] mask_t;

endpackage

// File: rtl/sni_mask_ram.sv
// 256 x PAT_LEN mask table: one write port, LANES registered read ports.
// Contents are intentionally not reset; software loads the table.
module sni_mask_ram #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned PAT_LEN = 16
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [7:0]                 i_waddr,
  input  logic [PAT_LEN-1:0]         i_wdata,
  input  logic [8*LANES-1:0]         i_raddr,
  output logic [PAT_LEN*LANES-1:0]   o_rdata
);

  logic [PAT_LEN-1:0] r_mem [256];

  // Reads in the write cycle see the old entry (both use pre-edge r_mem).
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    for (int j = 0; j < LANES; j++) begin
      o_rdata[PAT_LEN*j +: PAT_LEN] <= r_mem[i_raddr[8*j +: 8]];
    end
  end

endmodule

// File: rtl/sni_bitap_matcher_nbyte.sv
// Multi-lane shift-and SNI matcher: one verdict per frame plus first-match end offset.
// Optional build feature: SNI_WILDCARD_EN (adds i_cfg_wild, '*' = one or more non-dot bytes).
module sni_bitap_matcher_nbyte
  import sni_match_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned PAT_LEN = PAT_LEN_DEF,
  parameter int unsigned POS_W   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cfg_we,
  input  logic [7:0]                     i_cfg_addr,
  input  logic [PAT_LEN-1:0]             i_cfg_data,
  input  logic [$clog2(PAT_LEN+1)-1:0]   i_cfg_len,
`ifdef SNI_WILDCARD_EN
  input  logic [PAT_LEN-1:0]             i_cfg_wild,
`endif
  input  logic                           i_valid,
  input  logic                           i_sop,
  input  logic                           i_eop,
  input  logic [LANES-1:0]               i_keep,
  input  logic [8*LANES-1:0]             i_data,
  output logic                           o_done,
  output logic                           o_match,
  output logic [POS_W-1:0]               o_match_pos,
  output logic                           o_abort
);

  localparam int unsigned LEN_W = $clog2(PAT_LEN + 1);
  localparam int unsigned IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned CNT_W = POS_W + 1;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  function automatic logic [POS_W-1:0] sat_pos(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(POS_MAX)) ? POS_MAX : POS_W'(v);
  endfunction

  fsm_state_t           r_state;
  logic                 r_p_valid, r_p_sop, r_p_eop;
  logic [LANES-1:0]     r_p_keep;
  logic [LEN_W-1:0]     r_len, r_p_len;
`ifdef SNI_WILDCARD_EN
  logic [PAT_LEN-1:0]   r_wild, r_p_wild;
  logic [8*LANES-1:0]   r_p_data;
`endif
  logic [PAT_LEN-1:0]   r_s;
  logic [POS_W-1:0]     r_cnt, r_hit_pos;
  logic                 r_hit;

  logic                 w_start, w_accept;
  logic [LEN_W-1:0]     w_len_clamp;
  logic [PAT_LEN*LANES-1:0] w_rdata;
  logic [PAT_LEN-1:0]   w_s_next;
  logic [LANES-1:0]     w_lane_hit;
  logic [POS_W-1:0]     w_first_pos, w_cnt_next;
  logic                 w_hit_prev, w_hit_beat;
  logic [IDX_W-1:0]     w_idx;

  sni_mask_ram #(.LANES(LANES), .PAT_LEN(PAT_LEN)) u_mask_ram (
    .i_clk   (i_clk),
    .i_we    (i_cfg_we),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_data),
    .i_raddr (i_data),
    .o_rdata (w_rdata)
  );

  // Beat acceptance: outside a frame only an SOP beat opens one.
  always_comb begin
    w_start     = i_valid && i_sop;
    w_accept    = (r_state == ST_ACTIVE) ? i_valid : w_start;
    w_len_clamp = (i_cfg_len > LEN_W'(PAT_LEN)) ? LEN_W'(PAT_LEN) : i_cfg_len;
  end

  // Stage 0: frame FSM and beat controls aligned with the registered mask read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_p_valid <= 1'b0;
      r_p_sop   <= 1'b0;
      r_p_eop   <= 1'b0;
      r_p_keep  <= '0;
      r_len     <= '0;
      r_p_len   <= '0;
`ifdef SNI_WILDCARD_EN
      r_wild    <= '0;
      r_p_wild  <= '0;
      r_p_data  <= '0;
`endif
      o_abort   <= 1'b0;
    end else begin
      o_abort   <= (r_state == ST_ACTIVE) && w_start;
      r_p_valid <= w_accept;
      r_p_sop   <= w_start;
      r_p_eop   <= i_eop;
      r_p_keep  <= i_keep;
      r_p_len   <= w_start ? w_len_clamp : r_len;
      if (w_start) r_len <= w_len_clamp;
`ifdef SNI_WILDCARD_EN
      r_p_wild  <= w_start ? i_cfg_wild : r_wild;
      r_p_data  <= i_data;
      if (w_start) r_wild <= i_cfg_wild;
`endif
      case (r_state)
        ST_IDLE, ST_REPORT: begin
          if (w_start) r_state <= i_eop ? ST_REPORT : ST_ACTIVE;
          else         r_state <= ST_IDLE;
        end
        ST_ACTIVE: begin
          if (i_valid && i_eop) r_state <= ST_REPORT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: lane chain over the masks, per-lane hit and byte offset.
  always_comb begin
    logic [PAT_LEN-1:0] v_s;
    logic [PAT_LEN-1:0] v_shift;
    logic [CNT_W-1:0]   v_sum;
    logic               v_found;
    w_idx       = IDX_W'(r_p_len - LEN_W'(1));
    v_s         = r_p_sop ? '1 : r_s;
    v_sum       = r_p_sop ? '0 : {1'b0, r_cnt};
    v_found     = 1'b0;
    v_shift     = v_s;
    w_lane_hit  = '0;
    w_first_pos = '0;
    for (int j = 0; j < LANES; j++) begin
      if (r_p_keep[j]) begin
        v_shift = (v_s << 1) | w_rdata[PAT_LEN*j +: PAT_LEN];
`ifdef SNI_WILDCARD_EN
        // A wildcard position stays active across non-dot bytes.
        if (r_p_data[8*j +: 8] != DOT_BYTE) v_shift = v_shift & (v_s | ~r_p_wild);
`endif
        v_s           = v_shift;
        w_lane_hit[j] = (r_p_len != '0) && !v_s[w_idx];
        if (w_lane_hit[j] && !v_found) begin
          v_found     = 1'b1;
          w_first_pos = sat_pos(v_sum);
        end
        v_sum = v_sum + CNT_W'(1);
      end
    end
    w_s_next   = v_s;
    w_cnt_next = sat_pos(v_sum);
    w_hit_prev = !r_p_sop && r_hit;
    w_hit_beat = v_found;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s         <= '1;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_hit_pos   <= '0;
      o_done      <= 1'b0;
      o_match     <= 1'b0;
      o_match_pos <= '0;
    end else begin
      o_done <= 1'b0;
      if (r_p_valid) begin
        r_s   <= w_s_next;
        r_cnt <= w_cnt_next;
        r_hit <= w_hit_prev || w_hit_beat;
        if (!w_hit_prev && w_hit_beat) r_hit_pos <= w_first_pos;
        if (r_p_eop) begin
          o_done  <= 1'b1;
          o_match <= w_hit_prev || w_hit_beat;
          if (w_hit_prev)      o_match_pos <= r_hit_pos;
          else if (w_hit_beat) o_match_pos <= w_first_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_sni_bitap_matcher_nbyte.sv
// Directed and randomized bench for sni_bitap_matcher_nbyte with a substring-level reference.
module tb_sni_bitap_matcher_nbyte;

  localparam int unsigned LANES   = 4;
  localparam int unsigned PAT_LEN = 16;
  localparam int unsigned POS_W   = 16;

  logic        i_clk = 1'b0;
  logic        i_rst, i_cfg_we, i_valid, i_sop, i_eop;
  logic [7:0]  i_cfg_addr;
  logic [15:0] i_cfg_data;
  logic [4:0]  i_cfg_len;
  logic [3:0]  i_keep;
  logic [31:0] i_data;
`ifdef SNI_WILDCARD_EN
  logic [15:0] i_cfg_wild;
`endif
  logic        o_done, o_match, o_abort;
  logic [15:0] o_match_pos;

  always #5 i_clk = ~i_clk;

  sni_bitap_matcher_nbyte #(.LANES(LANES), .PAT_LEN(PAT_LEN), .POS_W(POS_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .i_cfg_len   (i_cfg_len),
`ifdef SNI_WILDCARD_EN
    .i_cfg_wild  (i_cfg_wild),
`endif
    .i_valid     (i_valid),
    .i_sop       (i_sop),
    .i_eop       (i_eop),
    .i_keep      (i_keep),
    .i_data      (i_data),
    .o_done      (o_done),
    .o_match     (o_match),
    .o_match_pos (o_match_pos),
    .o_abort     (o_abort)
  );

  int          n_checks = 0, n_pass = 0;
  int          n_done = 0, n_abort = 0, n_expected = 0;
  int          mdl_last_pos = 0;
  logic [15:0] mdl_mask [256];
  bit          exp_match_q[$];
  int          exp_pos_q[$];
  bit          mon_m;
  int          mon_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Verdict monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_abort) n_abort++;
    if (o_done) begin
      n_done++;
      check("done_expected", 32'(exp_match_q.size() != 0), 32'd1);
      if (exp_match_q.size() != 0) begin
        mon_m = exp_match_q.pop_front();
        mon_p = exp_pos_q.pop_front();
        check("match", 32'(o_match), 32'(mon_m));
        check("match_pos", 32'(o_match_pos), 32'(mon_p));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_v(input bit m, input int p);
    exp_match_q.push_back(m);
    exp_pos_q.push_back(p);
    n_expected++;
    if (m) mdl_last_pos = p;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_data = d;
    step();
    i_cfg_we = 1'b0;
    mdl_mask[a] = d;
  endtask

  task automatic load_pattern(input string p);
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      d = '1;
      for (int k = 0; k < p.len(); k++) begin
        if (p[k] == 8'h2A) d[k] = (x == 8'h2E);
        else if (p[k] == 8'(x)) d[k] = 1'b0;
      end
      cfg_write(8'(x), d);
    end
  endtask

  task automatic drive_beat(input bit sop, input bit eop, input logic [3:0] keep, input logic [31:0] data);
    i_valid = 1'b1; i_sop = sop; i_eop = eop; i_keep = keep; i_data = data;
    step();
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  function automatic logic [3:0] keep_of(input string s);
    logic [3:0] k = '0;
    for (int j = 0; j < s.len(); j++) k[j] = 1'b1;
    return k;
  endfunction

  function automatic logic [31:0] beat_data(input string s);
    logic [31:0] d = $urandom;
    for (int j = 0; j < s.len(); j++) d[8*j +: 8] = s[j];
    return d;
  endfunction

  task automatic db(input bit sop, input bit eop, input string s);
    drive_beat(sop, eop, keep_of(s), beat_data(s));
  endtask

  // Reference: first end index i where the last L bytes each satisfy their mask position.
  function automatic void ref_match(input logic [7:0] q[$], input int cfg, output bit m, output int pos);
    int L;
    bit ok;
    L = (cfg > 16) ? 16 : cfg;
    m = 1'b0; pos = 0;
    if (L == 0) return;
    for (int i = L - 1; i < q.size(); i++) begin
      ok = 1'b1;
      for (int k = 0; k < L; k++) if (mdl_mask[q[i-L+1+k]][k]) ok = 1'b0;
      if (ok && !m) begin m = 1'b1; pos = i; end
    end
  endfunction

  task automatic send_frame(input logic [7:0] q[$], input int cfg);
    int idx, n;
    bit first;
    logic [3:0]  keep;
    logic [31:0] data;
    idx = 0; first = 1'b1;
    while (idx < q.size()) begin
      n = $urandom_range(1, 4);
      if (n > q.size() - idx) n = q.size() - idx;
      keep = '0; data = $urandom;
      for (int j = 0; j < n; j++) begin
        data[8*j +: 8] = q[idx+j];
        keep[j] = 1'b1;
      end
      idx += n;
      if (first) i_cfg_len = 5'(cfg);
      drive_beat(first, idx == q.size(), keep, data);
      first = 1'b0;
    end
  endtask

  function automatic logic [7:0] alpha();
    case ($urandom_range(0, 2))
      0:       return 8'h61;
      1:       return 8'h62;
      default: return 8'h6E;
    endcase
  endfunction

  initial begin
    int a0, d0, plen, flen, cfg, pos;
    bit m;
    string pat;
    logic [7:0] q[$];

    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0; i_cfg_len = 5'd4;
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_keep = '0; i_data = '0;
`ifdef SNI_WILDCARD_EN
    i_cfg_wild = '0;
`endif
    repeat (3) step();
    check("rst_done", 32'(o_done), 0);
    check("rst_match", 32'(o_match), 0);
    check("rst_pos", 32'(o_match_pos), 0);
    check("rst_abort", 32'(o_abort), 0);
    i_rst = 1'b0;
    load_pattern("nntp");

    // Basic match with latency check.
    expect_v(1'b1, 4);
    db(1, 0, "xnnt"); db(0, 0, "ps.c"); db(0, 1, "om");
    check("lat_cycle1", 32'(o_done), 0);
    step();
    check("lat_cycle2", 32'(o_done), 1);
    repeat (3) step();

    expect_v(1'b0, 4);
    db(1, 0, "nnt"); db(0, 1, "xp");
    repeat (4) step();

    expect_v(1'b1, 5);
    db(1, 0, "..nn"); db(0, 1, "tp..");
    repeat (4) step();

    // SOP inside an open frame.
    a0 = n_abort; d0 = n_done;
    expect_v(1'b1, 3);
    db(1, 0, "abcd"); db(1, 1, "nntp");
    repeat (4) step();
    check("abort_pulse", 32'(n_abort - a0), 1);
    check("abort_one_done", 32'(n_done - d0), 1);

    // Back-to-back single-beat frames.
    d0 = n_done;
    expect_v(1'b1, 3); expect_v(1'b0, 3); expect_v(1'b1, 3);
    db(1, 1, "nntp"); db(1, 1, "xxxx"); db(1, 1, "nntp");
    repeat (4) step();
    check("b2b_dones", 32'(n_done - d0), 3);

    i_cfg_len = 5'd0;
    expect_v(1'b0, 3);
    db(1, 1, "nntp");
    i_cfg_len = 5'd4;
    repeat (4) step();

    // Table write during a beat: that beat sees old data, the next beat sees new.
    expect_v(1'b1, 4);
    i_cfg_we = 1'b1; i_cfg_addr = 8'h6E; i_cfg_data = 16'hFFFF;
    db(1, 0, "xnnt");
    i_cfg_we = 1'b0; mdl_mask[8'h6E] = 16'hFFFF;
    db(0, 1, "p");
    repeat (3) step();
    cfg_write(8'h6E, 16'hFFFC);
    expect_v(1'b0, 4);
    i_cfg_we = 1'b1; i_cfg_addr = 8'h6E; i_cfg_data = 16'hFFFF;
    db(1, 0, "xxxx");
    i_cfg_we = 1'b0; mdl_mask[8'h6E] = 16'hFFFF;
    db(0, 1, "nntp");
    repeat (3) step();
    cfg_write(8'h6E, 16'hFFFC);

    // Reset mid-frame drops the frame; a later non-SOP beat is ignored.
    d0 = n_done; a0 = n_abort;
    db(1, 0, "nntp");
    i_rst = 1'b1;
    db(0, 1, "xx");
    i_rst = 1'b0;
    db(0, 1, "p");
    repeat (5) step();
    check("rst_mid_no_done", 32'(n_done - d0), 0);
    check("rst_mid_no_abort", 32'(n_abort - a0), 0);
    check("rst_mid_match", 32'(o_match), 0);
    check("rst_mid_pos", 32'(o_match_pos), 0);
    mdl_last_pos = 0;

`ifdef SNI_WILDCARD_EN
    load_pattern("*.ex");
    i_cfg_wild = 16'h0001;
    expect_v(1'b1, 4);
    db(1, 0, "ab.e"); db(0, 1, "x");
    expect_v(1'b0, 4);
    db(1, 1, ".ex");
    expect_v(1'b1, 5);
    db(1, 0, "a.b."); db(0, 1, "ex");
    repeat (4) step();
    i_cfg_wild = 16'h0000;
`endif

    // Randomized frames against the reference.
    for (int f = 0; f < 40; f++) begin
      if (f % 8 == 0) begin
        plen = $urandom_range(1, 6);
        pat = "aaaaaa";
        for (int k = 0; k < 6; k++) pat.putc(k, alpha());
        pat = pat.substr(0, plen - 1);
        repeat (3) step();
        load_pattern(pat);
      end
      flen = $urandom_range(1, 14);
      q.delete();
      for (int k = 0; k < flen; k++) q.push_back(alpha());
      case ($urandom_range(0, 9))
        0:       cfg = 0;
        1:       cfg = $urandom_range(16, 31);
        2, 3:    cfg = $urandom_range(1, plen);
        default: cfg = plen;
      endcase
      ref_match(q, cfg, m, pos);
      expect_v(m, m ? pos : mdl_last_pos);
      send_frame(q, cfg);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (6) step();
    check("scoreboard_empty", 32'(exp_match_q.size()), 0);
    check("done_count", 32'(n_done), 32'(n_expected));
    check("abort_total", 32'(n_abort), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
